// File: rtl/multicycle_control.sv
// multicycle_control
//   Moore main-control FSM for a multicycle MIPS datapath. Each instruction
//   is sequenced through FETCH/DECODE and then its execute, memory and
//   writeback states. The FSM drives the shared-ALU, IR, PC and memory-port
//   controls. Supported instructions: R-type, lw, sw, beq, addi and j.
//   Opcode values are parameters.
//
//   Optional build macro: MEM_WAIT_EN
//     defined   -> the mem_ready port exists. FETCH, MEMRD and MEMWR hold
//                  while mem_ready=0. IRWrite/PCWrite fire only on the
//                  ready cycle.
//     undefined -> no mem_ready port. Every state lasts one cycle.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   opcode[5:0]       IR[31:26], sampled in DECODE and MEMADR
//   mem_ready         memory access complete (MEM_WAIT_EN only)
//   PCWrite .. RegDst 1-bit datapath controls
//   PCSource[1:0]     00 ALU, 01 ALUOut, 10 jump target
//   ALUSrcB[1:0]      00 B, 01 const 4, 10 sign-ext imm, 11 shifted imm
//   ALUOp[ALUOP_W-1:0] 00 add, 01 sub, 10 funct-decoded (upper bits 0)
//   state[3:0]        current state (debug)
//   illegal_op        DECODE with an unrecognised opcode
module multicycle_control #(
  parameter int          ALUOP_W  = 2,
  parameter logic [5:0]  OP_RTYPE = 6'b000000,
  parameter logic [5:0]  OP_LW    = 6'b100011,
  parameter logic [5:0]  OP_SW    = 6'b101011,
  parameter logic [5:0]  OP_BEQ   = 6'b000100,
  parameter logic [5:0]  OP_ADDI  = 6'b001000,
  parameter logic [5:0]  OP_J     = 6'b000010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
`ifdef MEM_WAIT_EN
  input  logic               mem_ready,
`endif
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [3:0]         state,
  output logic               illegal_op
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;
  localparam logic [3:0] S_ADDIEX = 4'd10;
  localparam logic [3:0] S_ADDIWB = 4'd11;

  logic [3:0] state_q, state_d;
  logic       mem_rdy;
  logic       op_known;
  logic [1:0] alu_op;

`ifdef MEM_WAIT_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  assign op_known = (opcode == OP_RTYPE) || (opcode == OP_LW)  ||
                    (opcode == OP_SW)    || (opcode == OP_BEQ) ||
                    (opcode == OP_ADDI)  || (opcode == OP_J);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = mem_rdy ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if      (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)                 state_d = S_EXEC;
        else if (opcode == OP_BEQ)                   state_d = S_BRANCH;
        else if (opcode == OP_J)                     state_d = S_JUMP;
        else if (opcode == OP_ADDI)                  state_d = S_ADDIEX;
        else                                         state_d = S_FETCH;
      end
      // The opcode must be held stable, so only lw/sw can appear here.
      // Anything else returns to FETCH rather than wandering.
      S_MEMADR: begin
        if      (opcode == OP_LW) state_d = S_MEMRD;
        else if (opcode == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:  state_d = mem_rdy ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_rdy ? S_FETCH : S_MEMWR;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode (Moore; mem_ready gates only the FETCH write enables)
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op      = 2'b00;
    illegal_op  = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // Latch the IR and advance the PC exactly once, on the ready cycle.
        IRWrite = mem_rdy;
        PCWrite = mem_rdy;
      end
      S_DECODE: begin
        ALUSrcB    = 2'b11;
        illegal_op = ~op_known;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        alu_op      = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    ALUOp      = '0;
    ALUOp[1:0] = alu_op;
  end

  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
`ifdef MEM_WAIT_EN
  logic       mem_ready;
`endif
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst, illegal_op;
  logic [1:0] PCSource, ALUSrcB, ALUOp;
  logic [3:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode),
`ifdef MEM_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA),
    .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .state(state), .illegal_op(illegal_op)
  );

  typedef struct packed {
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcs, srcb, aop;
    logic ill;
  } ctl_t;

  function automatic ctl_t dut_ctl();
    ctl_t c;
    c = '{PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
          ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp, illegal_op};
    return c;
  endfunction

  function automatic bit is_legal(input logic [5:0] op);
    return op == OP_R || op == OP_LW || op == OP_SW || op == OP_BEQ ||
           op == OP_ADDI || op == OP_J;
  endfunction

  // Reference: the state walk of one instruction, straight from its class.
  function automatic void path_of(input logic [5:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      OP_R:    p = {0, 1, 6, 7};
      OP_LW:   p = {0, 1, 2, 3, 4};
      OP_SW:   p = {0, 1, 2, 5};
      OP_BEQ:  p = {0, 1, 8};
      OP_J:    p = {0, 1, 9};
      OP_ADDI: p = {0, 1, 10, 11};
      default: p = {0, 1};
    endcase
  endfunction

  // Reference: which controls each named step asserts.
  function automatic ctl_t model_ctl(input int s, input logic [5:0] op, input logic rdy);
    ctl_t c = '0;
    case (s)
      0:  begin c.mrd = 1; c.srcb = 2'b01; c.irw = rdy; c.pcw = rdy; end
      1:  begin c.srcb = 2'b11; c.ill = !is_legal(op); end
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aop = 2'b10; end
      7:  begin c.rdst = 1; c.rw = 1; end
      8:  begin c.srca = 1; c.aop = 2'b01; c.pcwc = 1; c.pcs = 2'b01; end
      9:  begin c.pcw = 1; c.pcs = 2'b10; end
      10: begin c.srca = 1; c.srcb = 2'b10; end
      11: begin c.rw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  // Runs one instruction starting from a negedge in FETCH. stall_rd>0 forces
  // that many not-ready cycles in MEMRD; stall_rd<0 randomises mem_ready.
  task automatic run_instr(input logic [5:0] op, input int stall_rd, input string name);
    int   p[$];
    int   k, cyc, waits, rd_stalls;
    logic rdy;
    ctl_t exp_c, act_c;
    path_of(op, p);
    opcode = op;
    k = 0; cyc = 0; waits = 0; rd_stalls = 0;
    while (k < p.size()) begin
      rdy = 1'b1;
`ifdef MEM_WAIT_EN
      if (stall_rd > 0 && p[k] == 3 && rd_stalls < stall_rd) rdy = 1'b0;
      else if (stall_rd < 0 && (p[k] == 0 || p[k] == 3 || p[k] == 5))
        rdy = ($urandom_range(0, 2) != 0);
      mem_ready = rdy;
`endif
      #1;
      n_tests++;
      if (state !== 4'(p[k])) begin
        n_fail++;
        $display("FAIL %s state step%0d: got %0d expected %0d", name, k, state, p[k]);
      end
      exp_c = model_ctl(p[k], op, rdy);
      act_c = dut_ctl();
      n_tests++;
      if (act_c !== exp_c) begin
        n_fail++;
        $display("FAIL %s ctl in state %0d: got %h expected %h", name, p[k], act_c, exp_c);
      end
      @(posedge clk); @(negedge clk);
      cyc++;
      if ((p[k] == 0 || p[k] == 3 || p[k] == 5) && !rdy) begin
        waits++;
        if (p[k] == 3) rd_stalls++;
      end else k++;
      if (cyc > 100) begin
        n_fail++;
        $display("FAIL %s timeout: got %0d cycles expected %0d", name, cyc, p.size() + waits);
        break;
      end
    end
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL %s end state: got %0d expected 0", name, state);
    end
    if (stall_rd > 0) begin
      n_tests++;
`ifdef MEM_WAIT_EN
      if (rd_stalls != stall_rd) begin
`else
      if (rd_stalls != 0) begin
`endif
        n_fail++;
        $display("FAIL %s memrd stalls: got %0d expected %0d", name, rd_stalls, stall_rd);
      end
    end
  endtask

  task automatic test_reset();
    ctl_t exp_c;
    rst_n = 1'b0; opcode = OP_R;
`ifdef MEM_WAIT_EN
    mem_ready = 1'b1;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    exp_c = '0; exp_c.mrd = 1; exp_c.irw = 1; exp_c.pcw = 1; exp_c.srcb = 2'b01;
    n_tests++;
    if (state !== 4'd0 || dut_ctl() !== exp_c) begin
      n_fail++;
      $display("FAIL reset_values: got state %0d ctl %h expected state 0 ctl %h", state, dut_ctl(), exp_c);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (state !== 4'd1) begin
      n_fail++;
      $display("FAIL reset_release: got state %0d expected 1", state);
    end
    rst_n = 1'b0; #1;
    n_tests++;
    if (state !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_async: got state %0d expected 0", state);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();   run_instr(OP_R, 0, "rtype");   endtask
  task automatic test_addi();    run_instr(OP_ADDI, 0, "addi"); endtask
  task automatic test_sw();      run_instr(OP_SW, 0, "sw");     endtask
  task automatic test_lw_wait(); run_instr(OP_LW, 2, "lw_wait"); endtask
  task automatic test_beq_j();
    run_instr(OP_BEQ, 0, "beq");
    run_instr(OP_J, 0, "j");
  endtask
  task automatic test_illegal(); run_instr(6'b111111, 0, "illegal"); endtask

  task automatic test_reset_abort();
    opcode = OP_SW;
    repeat (3) @(negedge clk);   // DECODE, MEMADR, MEMWR
    n_tests++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_reach_memwr: got state %0d MemWrite %b expected 5 1", state, MemWrite);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: got state %0d MemWrite %b RegWrite %b expected 0 0 0",
               state, MemWrite, RegWrite);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [5:0] legal [6] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    logic [5:0] op;
    int idx;
    for (int i = 0; i < 40; i++) begin
      idx = $urandom_range(0, 6);
      op = (idx == 6) ? 6'($urandom) : legal[idx];
      run_instr(op, -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq_j();
    test_addi();
    test_sw();
    test_illegal();
    test_reset_abort();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
